// File: rtl/temp_sensor_pkg.sv
// Shared definitions for the multi-channel temperature sensor controller:
// per-channel state encoding and default timing constants.
package temp_sensor_pkg;

  typedef enum logic [5:0] {
    CH_IDLE = 6'b000001,
    CH_LOW  = 6'b000010,
    CH_HIGH = 6'b000100,
    CH_WAIT = 6'b001000,
    CH_MEAS = 6'b010000,
    CH_DONE = 6'b100000
  } ch_state_e;

  localparam int DEF_N_CH           = 4;
  localparam int DEF_COUNT_WIDTH    = 32;
  localparam int DEF_LOW_CYCLES     = 20;
  localparam int DEF_HIGH_CYCLES    = 30;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/temp_sensor_array_ts_channel.sv
// One sensor channel: excitation driver, input synchroniser, pulse-width
// measurement with saturation, and timeout handling.
module ts_channel
  import temp_sensor_pkg::*;
#(
  parameter int COUNT_W        = DEF_COUNT_WIDTH,
  parameter int LOW_CYCLES     = DEF_LOW_CYCLES,
  parameter int HIGH_CYCLES    = DEF_HIGH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  inout  wire                ts_line,
  output logic [COUNT_W-1:0] result,
  output logic               valid,
  output logic               tmo_flag,
  output logic               fin
);

  localparam int MAX_PH = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int MAX_C  = (TIMEOUT_CYCLES > MAX_PH) ? TIMEOUT_CYCLES : MAX_PH;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  ch_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] width_q, width_d, result_q, result_d;
  logic               valid_q, valid_d, tmo_q, tmo_d;
  logic               sync1_q, sync2_q;
  logic               drive_oe, drive_val;

  assign drive_oe  = (state_q == CH_LOW) || (state_q == CH_HIGH);
  assign drive_val = (state_q == CH_HIGH);
  assign ts_line   = drive_oe ? drive_val : 1'bz;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    result_d = result_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    case (state_q)
      CH_IDLE: if (start) begin
        state_d = CH_LOW;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
      CH_LOW: if (cnt_q == CNT_W'(LOW_CYCLES - 1)) begin
        state_d = CH_HIGH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      CH_HIGH: if (cnt_q == CNT_W'(HIGH_CYCLES - 1)) begin
        state_d = CH_WAIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      CH_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sync2_q) begin
          state_d = CH_MEAS;
          width_d = COUNT_W'(1);
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = CH_DONE;
          tmo_d   = 1'b1;
        end
      end
      CH_MEAS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A falling edge on the timeout cycle still counts as a good result
        if (!sync2_q) begin
          state_d  = CH_DONE;
          result_d = width_q;
          valid_d  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = CH_DONE;
          tmo_d   = 1'b1;
        end else begin
          width_d = sat_inc(width_q);
        end
      end
      CH_DONE: state_d = CH_IDLE;
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CH_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      // Our own excitation must not look like a sensor reply
      sync1_q  <= drive_oe ? 1'b0 : ts_line;
      sync2_q  <= sync1_q;
    end
  end

  assign result   = result_q;
  assign valid    = valid_q;
  assign tmo_flag = tmo_q;
  assign fin      = (state_q == CH_DONE);

endmodule

// File: rtl/temp_sensor_array.sv
// Multi-channel Mic4 temperature sensor controller: start edge detection,
// channel mask latch, and busy/done aggregation over ts_channel instances.
module temp_sensor_array
  import temp_sensor_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int TS_COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int LOW_CYCLES     = DEF_LOW_CYCLES,
  parameter int HIGH_CYCLES    = DEF_HIGH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk_100MHz,
  input  logic                           RESET,
  input  logic                           pulse_in,
  input  logic [N_CH-1:0]                ch_mask,
  inout  wire  [N_CH-1:0]                ts_data,
  output logic [N_CH*TS_COUNT_WIDTH-1:0] MEM_OUT,
  output logic [N_CH-1:0]                valid_out,
  output logic [N_CH-1:0]                timeout_flag,
  output logic                           busy,
  output logic                           done
);

  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [N_CH-1:0] mask_q, mask_d, fin_seen_q, fin_seen_d;
  logic [N_CH-1:0] ch_fin;
  logic            accept;

  assign accept = pulse_in & ~pulse_q & ~busy_q & (|ch_mask);

  always_comb begin
    pulse_d    = pulse_in;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mask_d     = mask_q;
    fin_seen_d = fin_seen_q;
    if (accept) begin
      busy_d     = 1'b1;
      mask_d     = ch_mask;
      fin_seen_d = '0;
    end else if (busy_q) begin
      fin_seen_d = fin_seen_q | ch_fin;
      if (&(fin_seen_d | ~mask_q)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (RESET) begin
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mask_q     <= '0;
      fin_seen_q <= '0;
    end else begin
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mask_q     <= mask_d;
      fin_seen_q <= fin_seen_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ts_channel #(
      .COUNT_W       (TS_COUNT_WIDTH),
      .LOW_CYCLES    (LOW_CYCLES),
      .HIGH_CYCLES   (HIGH_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk     (clk_100MHz),
      .rst     (RESET),
      .start   (accept & ch_mask[g]),
      .ts_line (ts_data[g]),
      .result  (MEM_OUT[g*TS_COUNT_WIDTH +: TS_COUNT_WIDTH]),
      .valid   (valid_out[g]),
      .tmo_flag(timeout_flag[g]),
      .fin     (ch_fin[g])
    );
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_temp_sensor_array.sv
// Bench for temp_sensor_array: scheduled sensor replies, a cycle-level
// behavioural model of expected outputs, and directed plus random scenarios.
module tb_temp_sensor_array;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 20;
  localparam int H = 30;
  localparam int T = 400;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pulse_in = 1'b0;
  logic [N-1:0]   ch_mask = '0;
  wire  [N-1:0]   ts_data;
  logic [N*W-1:0] mem_out;
  logic [N-1:0]   valid_out, timeout_flag;
  logic           busy, done;
  logic [N-1:0]   tb_oe = '0;

  temp_sensor_array #(
    .N_CH(N), .TS_COUNT_WIDTH(W), .LOW_CYCLES(L), .HIGH_CYCLES(H), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_100MHz(clk), .RESET(rst), .pulse_in(pulse_in), .ch_mask(ch_mask),
    .ts_data(ts_data), .MEM_OUT(mem_out), .valid_out(valid_out),
    .timeout_flag(timeout_flag), .busy(busy), .done(done)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_drv
    assign ts_data[gi] = tb_oe[gi] ? 1'b1 : 1'bz;
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int plan_d[N];
  int plan_w[N];

  bit           prev_pulse = 0;
  bit           m_active = 0;
  int           m_A, m_R, m_D;
  logic [N-1:0] m_mask = '0;
  int           m_d[N], m_w[N], m_fin[N], m_res[N];
  bit           m_tmo[N];
  int           e_mem[N];
  logic [N-1:0] e_tf = '0, e_valid = '0;
  bit           e_busy = 0, e_done = 0;
  int           n_done_obs = 0, obs_done_cyc = 0;
  logic [N-1:0] obs_valid_last = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update at each edge, sensor drive just after it, compare at the falling edge
  initial begin
    for (int i = 0; i < N; i++) begin e_mem[i] = 0; m_w[i] = 0; m_d[i] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 0; prev_pulse = 0; e_busy = 0; e_done = 0; e_valid = '0; e_tf = '0;
        for (int i = 0; i < N; i++) e_mem[i] = 0;
      end else begin
        bit rise, busy_before;
        rise = pulse_in && !prev_pulse;
        prev_pulse = pulse_in;
        busy_before = e_busy;
        e_valid = '0;
        e_done = 0;
        if (rise && !busy_before && ch_mask != '0) begin
          m_active = 1; m_A = cyc; m_R = cyc + L + H; m_mask = ch_mask; m_D = 0;
          for (int i = 0; i < N; i++) begin
            m_d[i] = plan_d[i];
            m_w[i] = plan_w[i];
            if (m_mask[i]) begin
              e_tf[i] = 1'b0;
              if (m_w[i] > 0 && m_d[i] + m_w[i] + 3 <= T) begin
                m_tmo[i] = 0;
                m_fin[i] = m_R + m_d[i] + m_w[i] + 3;
                m_res[i] = (m_w[i] > 255) ? 255 : m_w[i];
              end else begin
                m_tmo[i] = 1;
                m_fin[i] = m_R + T;
              end
              if (m_fin[i] + 1 > m_D) m_D = m_fin[i] + 1;
            end
          end
        end
        if (m_active) begin
          e_busy = (cyc < m_D);
          e_done = (cyc == m_D);
          for (int i = 0; i < N; i++) begin
            if (m_mask[i] && cyc == m_fin[i]) begin
              if (m_tmo[i]) e_tf[i] = 1'b1;
              else begin e_valid[i] = 1'b1; e_mem[i] = m_res[i]; end
            end
          end
          if (cyc == m_D) m_active = 0;
        end else begin
          e_busy = 0;
        end
      end
      #1;
      for (int i = 0; i < N; i++)
        tb_oe[i] = m_active && m_mask[i] && m_w[i] > 0 &&
                   cyc >= m_R + m_d[i] && cyc < m_R + m_d[i] + m_w[i];
      @(negedge clk);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("valid_out", valid_out, e_valid);
      chk("timeout_flag", timeout_flag, e_tf);
      for (int i = 0; i < N; i++) begin
        chk("mem_slice", mem_out[i*W +: W], e_mem[i]);
        if (m_active && m_mask[i]) begin
          if (cyc >= m_A && cyc < m_A + L) chk("drive_low", ts_data[i], 0);
          else if (cyc >= m_A + L && cyc < m_R) chk("drive_high", ts_data[i], 1);
        end
      end
      if (done) begin n_done_obs++; obs_done_cyc = cyc; end
      if (valid_out != '0) obs_valid_last = valid_out;
    end
  end

  task automatic start_conv(input logic [N-1:0] mask, output int acc_cyc);
    @(negedge clk);
    ch_mask = mask;
    pulse_in = 1'b1;
    @(negedge clk);
    pulse_in = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) begin
      total++; bad++;
      $display("FAIL %s: no done within 3000 cycles, want done=1", name);
    end
    @(negedge clk);
  endtask

  task automatic set_plan(input int d0, w0, d1, w1, d2, w2, d3, w3);
    plan_d[0] = d0; plan_w[0] = w0; plan_d[1] = d1; plan_w[1] = w1;
    plan_d[2] = d2; plan_w[2] = w2; plan_d[3] = d3; plan_w[3] = w3;
  endtask

  initial begin
    int a, n0;
    logic [N-1:0] m;
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("reset_mem", mem_out, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single channel, 1 us reply
    set_plan(3, 100, 0, 0, 0, 0, 0, 0);
    start_conv(4'b0001, a);
    wait_done("t1_done");
    chk("t1_latency", obs_done_cyc - a, 157);
    chk("t1_mem0", mem_out[7:0], 100);
    chk("t1_valid", obs_valid_last, 4'b0001);
    chk("t1_busy", busy, 0);

    // all channels, staggered widths
    set_plan(0, 50, 0, 100, 0, 150, 0, 200);
    start_conv(4'b1111, a);
    wait_done("t2_done");
    chk("t2_latency", obs_done_cyc - a, 254);
    chk("t2_mem", mem_out, 32'hC8966432);

    // channel 1 never replies
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    start_conv(4'b0010, a);
    wait_done("t3_done");
    chk("t3_latency", obs_done_cyc - a, 451);
    chk("t3_tflag", timeout_flag, 4'b0010);
    chk("t3_mem", mem_out, 32'hC8966432);

    // mask=0 start and a second edge during busy are both dropped
    n0 = n_done_obs;
    start_conv(4'b0000, a);
    repeat (10) @(negedge clk);
    chk("t4_mask0_busy", busy, 0);
    set_plan(1, 20, 0, 0, 0, 0, 0, 0);
    start_conv(4'b0001, a);
    repeat (10) @(negedge clk);
    ch_mask = 4'b1111;
    pulse_in = 1'b1;
    @(negedge clk);
    pulse_in = 1'b0;
    wait_done("t4_done");
    repeat (100) @(negedge clk);
    chk("t4_done_count", n_done_obs - n0, 1);
    chk("t4_tflag_kept", timeout_flag, 4'b0010);
    chk("t4_mem0", mem_out[7:0], 20);

    // reply longer than the counter range saturates
    set_plan(0, 300, 0, 0, 0, 0, 0, 0);
    start_conv(4'b0001, a);
    wait_done("t6_done");
    chk("t6_sat", mem_out[7:0], 255);

    // reset while exciting
    set_plan(0, 10, 0, 10, 0, 10, 0, 10);
    start_conv(4'b1111, a);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t5_mem", mem_out, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tflag", timeout_flag, 0);
    repeat (100) @(negedge clk);

    // randomized conversions
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        plan_d[i] = $urandom_range(0, 5);
        plan_w[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 80);
      end
      m = 4'($urandom_range(0, 15));
      start_conv(m, a);
      if (m == '0) begin
        repeat (5) @(negedge clk);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(5, 40)) @(negedge clk);
          ch_mask = 4'($urandom_range(0, 15));
          pulse_in = 1'b1;
          @(negedge clk);
          pulse_in = 1'b0;
        end
        wait_done("rand_done");
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
